bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
Round-robin arbiter for the shared memory bus. Up to NUM_REQ bus masters (fetch, load/store, cache fill/writeback, page walker) request the bus. The arbiter issues a registered one-hot grant and holds it for the whole transaction. A hold-limit counter forces release so no master can starve the others.

Parameters:
NUM_REQ, 5, number of requesters (2..8)
ID_WIDTH, 3, width of bus_grant_id; must be >= clog2(NUM_REQ)
MAX_HOLD, 64, max consecutive granted cycles while another requester waits; 0 disables preemption
HOLD_CNT_WIDTH, 7, hold counter width; must hold MAX_HOLD

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
bus_reqcyc  input  NUM_REQ  per-master request, level; held high for the whole transaction
bus_busy  input  1  bus/memory side still completing a transfer
bus_grant  output  NUM_REQ  registered one-hot grant; all zero when no owner
bus_grant_valid  output  1  OR of bus_grant, registered
bus_grant_id  output  ID_WIDTH  index of current owner; holds last owner when no grant
bus_preempt  output  1  one-cycle pulse when the hold limit forced a release

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - bus_grant=0, bus_grant_valid=0, bus_grant_id=0, bus_preempt=0.
  - Priority pointer=0, hold counter=0, state=IDLE.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If bus_busy=0 and any bus_reqcyc bit is set, pick the first set index searching from the pointer upward, wrapping at NUM_REQ-1.
  - Register that grant, set bus_grant_id, clear the counter and go to GRANT.
  - Latency: request sampled at edge k, grant visible after edge k. No combinational path from request to grant.
  - bus_busy=1 blocks arbitration; stay in IDLE.
- GRANT:
  - Grant stays stable while bus_reqcyc[owner]=1.
  - The counter increments each cycle and saturates at MAX_HOLD.
  - Release A: bus_reqcyc[owner]=0 at edge -> grant cleared at that edge, go to DRAIN, bus_preempt=0.
  - Release B: MAX_HOLD!=0, counter==MAX_HOLD-1, and some other request bit is set -> grant cleared, bus_preempt=1 for exactly one cycle, go to DRAIN.
  - If no other request is pending at the limit, the counter saturates and the grant is held. Preemption fires on the first cycle another request appears.
  - On release, pointer = (owner+1) mod NUM_REQ.
  - If both release conditions hold on the same edge, release A wins and bus_preempt=0.
- DRAIN:
  - bus_grant=0.
  - Wait for bus_busy=0, then arbitrate exactly as in IDLE on that edge: go to GRANT if any request is set, otherwise go to IDLE.
  - Guarantees at least one grant-free cycle between owners.
  - A preempted master that keeps its request up simply competes again and is now lowest priority.
- Out-of-range request bits: bits beyond NUM_REQ do not exist. The owner is never a non-requesting index.
- Invariants:
  - bus_grant is always one-hot or zero.
  - bus_grant_valid == |bus_grant.
  - A grant never changes owner without an intervening all-zero cycle.

Test Plan:
- Reset with bus_reqcyc=5'b10110, bus_busy=0: first edge after reset release grants index 1 (bus_grant=5'b00010, id=1). Drop req1: next grant goes to index 2, then index 4, then back to 1.
- All five requesting continuously with short transactions (each drops its request 3 cycles after grant): grant order 0,1,2,3,4,0. Exactly one zero-grant cycle between owners; no owner repeats before the others are served.
- bus_busy held 1 for 10 cycles with req0 set: bus_grant stays 0. Grant appears on the edge after bus_busy falls. Same check in DRAIN after a release.
- MAX_HOLD=8, req2 held forever, req3 raised at cycle 3 of ownership: after 8 granted cycles the grant drops, bus_preempt pulses once, then index 3 is granted. With req3 never raised, req2 keeps the grant indefinitely.
- Owner drops its request on the same edge its hold limit is reached: release with bus_preempt=0.
- Assert reset mid-GRANT (bus_grant=5'b01000): outputs clear asynchronously before the next clock edge. After reset deassertion with req3 and req0 set, index 0 wins because the pointer is back at 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbiter
// Description : Round-robin arbiter for the shared memory bus. Issues a
//               registered one-hot grant held for a whole transaction, with a
//               hold-limit counter that forces release when others wait.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int ID_WIDTH       = 3,
  parameter int MAX_HOLD       = 64,
  parameter int HOLD_CNT_WIDTH = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  bus_reqcyc,
  input  logic                bus_busy,
  output logic [NUM_REQ-1:0]  bus_grant,
  output logic                bus_grant_valid,
  output logic [ID_WIDTH-1:0] bus_grant_id,
  output logic                bus_preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ID_WIDTH-1:0]       c_last_id  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [HOLD_CNT_WIDTH-1:0] c_cnt_lim  = HOLD_CNT_WIDTH'(MAX_HOLD - 1);
  localparam logic [HOLD_CNT_WIDTH-1:0] c_cnt_sat  = HOLD_CNT_WIDTH'(MAX_HOLD);

  state_t                    r_state, w_state_nxt;
  logic [NUM_REQ-1:0]        r_grant, w_grant_nxt;
  logic                      r_grant_valid;
  logic [ID_WIDTH-1:0]       r_grant_id, w_grant_id_nxt;
  logic                      r_preempt, w_preempt_nxt;
  logic [ID_WIDTH-1:0]       r_ptr, w_ptr_nxt;
  logic [HOLD_CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;

  logic [NUM_REQ-1:0]        w_pick_sel;
  logic [ID_WIDTH-1:0]       w_pick_id;
  logic                      w_found;
  logic                      w_owner_req;
  logic                      w_other_req;
  logic [ID_WIDTH-1:0]       w_ptr_adv;

  // Rotating-priority pick: first requester at or above the pointer, else
  // first requester from index 0 (the wrap-around half of the search).
  always_comb begin
    w_pick_sel = '0;
    w_pick_id  = '0;
    w_found    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && bus_reqcyc[j] && (j >= int'(r_ptr))) begin
        w_found       = 1'b1;
        w_pick_sel[j] = 1'b1;
        w_pick_id     = ID_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && bus_reqcyc[j]) begin
        w_found       = 1'b1;
        w_pick_sel[j] = 1'b1;
        w_pick_id     = ID_WIDTH'(j);
      end
    end
  end

  // Owner/others request status derived from the one-hot grant, and the
  // pointer value that makes the current owner lowest priority next time.
  always_comb begin
    w_owner_req = |(bus_reqcyc & r_grant);
    w_other_req = |(bus_reqcyc & ~r_grant);
    w_ptr_adv   = (r_grant_id == c_last_id) ? '0 : r_grant_id + ID_WIDTH'(1);
  end

  // Next-state and next-output logic for the IDLE/GRANT/DRAIN machine.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_preempt_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      IDLE, DRAIN: begin
        w_grant_nxt = '0;
        if (!bus_busy) begin
          if (w_found) begin
            w_grant_nxt    = w_pick_sel;
            w_grant_id_nxt = w_pick_id;
            w_cnt_nxt      = '0;
            w_state_nxt    = GRANT;
          end else begin
            w_state_nxt    = IDLE;
          end
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          // Owner finished; takes priority over a simultaneous preemption.
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = DRAIN;
        end else if ((MAX_HOLD != 0) && (r_cnt == c_cnt_lim) && w_other_req) begin
          w_grant_nxt   = '0;
          w_preempt_nxt = 1'b1;
          w_ptr_nxt     = w_ptr_adv;
          w_state_nxt   = DRAIN;
        end else if (r_cnt != c_cnt_sat) begin
          w_cnt_nxt = r_cnt + HOLD_CNT_WIDTH'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_preempt     <= 1'b0;
      r_ptr         <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_preempt     <= w_preempt_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign bus_grant       = r_grant;
  assign bus_grant_valid = r_grant_valid;
  assign bus_grant_id    = r_grant_id;
  assign bus_preempt     = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_rr_arbiter
// Description : Self-checking bench for bus_rr_arbiter. Expected owners are
//               queued as stimulus is applied and compared on each new grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_arbiter;

  localparam int NUM_REQ = 5;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] bus_reqcyc = '0;
  logic               bus_busy = 1'b0;
  logic [NUM_REQ-1:0] bus_grant;
  logic               bus_grant_valid;
  logic [ID_W-1:0]    bus_grant_id;
  logic               bus_preempt;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  bus_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_W), .MAX_HOLD(8), .HOLD_CNT_WIDTH(7)
  ) dut (
    .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_busy(bus_busy),
    .bus_grant(bus_grant), .bus_grant_valid(bus_grant_valid),
    .bus_grant_id(bus_grant_id), .bus_preempt(bus_preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every new grant pops the next expected owner.
  logic               prev_valid = 1'b0;
  logic [NUM_REQ-1:0] prev_grant = '0;
  always @(negedge clk) begin
    int e;
    logic [NUM_REQ-1:0] oh;
    check("valid_is_or", {31'd0, bus_grant_valid}, {31'd0, |bus_grant});
    check("onehot_or_zero", {31'd0, $onehot0(bus_grant)}, 32'd1);
    if (prev_valid && bus_grant_valid)
      check("owner_stable", {27'd0, bus_grant}, {27'd0, prev_grant});
    if (bus_grant_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        oh = '0;
        oh[e] = 1'b1;
        check("grant_id", {29'd0, bus_grant_id}, e);
        check("grant_vec", {27'd0, bus_grant}, {27'd0, oh});
      end
    end
    prev_valid = bus_grant_valid;
    prev_grant = bus_grant;
  end

  task automatic wait_new_grant();
    int n = 0;
    while (bus_grant_valid && n < 40) begin @(negedge clk); n++; end
    while (!bus_grant_valid && n < 80) begin @(negedge clk); n++; end
    if (!bus_grant_valid) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; bus_reqcyc = '0; bus_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int order [6] = '{0, 1, 2, 3, 4, 0};
    int o;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 4, 0};

    // Reset values and first arbitration from pointer 0.
    bus_reqcyc = 5'b10110;
    @(negedge clk); @(negedge clk);
    check("rst_grant", {27'd0, bus_grant}, 32'd0);
    check("rst_valid", {31'd0, bus_grant_valid}, 32'd0);
    check("rst_id", {29'd0, bus_grant_id}, 32'd0);
    check("rst_preempt", {31'd0, bus_preempt}, 32'd0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(1);
    reset = 1'b0;
    @(negedge clk);
    check("first_lat_valid", {31'd0, bus_grant_valid}, 32'd1);
    check("first_lat_id", {29'd0, bus_grant_id}, 32'd1);
    bus_reqcyc = 5'b10100; wait_new_grant();
    bus_reqcyc = 5'b10000; wait_new_grant();
    bus_reqcyc = 5'b00010; wait_new_grant();
    bus_reqcyc = 5'b00000; repeat (3) @(negedge clk);

    // All five requesting, short transactions: 0,1,2,3,4,0.
    pulse_reset();
    bus_reqcyc = 5'b11111;
    foreach (order[k]) exp_q.push_back(order[k]);
    for (int n = 0; n < 6; n++) begin
      wait_new_grant();
      repeat (2) @(negedge clk);
      bus_reqcyc[order[n]] = 1'b0;
      @(negedge clk);
      check("rr_gap", {31'd0, bus_grant_valid}, 32'd0);
      if (n < 5) bus_reqcyc[order[n]] = 1'b1;
      else bus_reqcyc = '0;
    end
    repeat (3) @(negedge clk);

    // bus_busy blocks arbitration in IDLE, then in DRAIN.
    pulse_reset();
    bus_busy = 1'b1; bus_reqcyc = 5'b00001;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("busy_idle_grant", {27'd0, bus_grant}, 32'd0);
    end
    bus_busy = 1'b0; exp_q.push_back(0);
    @(negedge clk);
    check("busy_idle_lat", {31'd0, bus_grant_valid}, 32'd1);
    bus_busy = 1'b1; bus_reqcyc = 5'b00010;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("busy_drain_grant", {27'd0, bus_grant}, 32'd0);
    end
    bus_busy = 1'b0; exp_q.push_back(1);
    @(negedge clk);
    check("busy_drain_lat", {31'd0, bus_grant_valid}, 32'd1);
    check("busy_drain_id", {29'd0, bus_grant_id}, 32'd1);
    bus_reqcyc = '0; repeat (3) @(negedge clk);

    // Hold limit: req2 owns, req3 arrives at ownership cycle 3.
    pulse_reset();
    bus_reqcyc = 5'b00100; exp_q.push_back(2);
    wait_new_grant();
    for (int c = 1; c <= 8; c++) begin
      check("hold_valid", {31'd0, bus_grant_valid}, 32'd1);
      check("hold_no_preempt", {31'd0, bus_preempt}, 32'd0);
      if (c == 3) begin bus_reqcyc[3] = 1'b1; exp_q.push_back(3); end
      if (c < 8) @(negedge clk);
    end
    @(negedge clk);
    check("preempt_drop", {31'd0, bus_grant_valid}, 32'd0);
    check("preempt_pulse", {31'd0, bus_preempt}, 32'd1);
    @(negedge clk);
    check("preempt_once", {31'd0, bus_preempt}, 32'd0);
    check("preempt_next_id", {29'd0, bus_grant_id}, 32'd3);
    bus_reqcyc = 5'b00100; exp_q.push_back(2);
    wait_new_grant();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_forever_valid", {31'd0, bus_grant_valid}, 32'd1);
      check("hold_forever_nopre", {31'd0, bus_preempt}, 32'd0);
    end
    bus_reqcyc = '0; repeat (3) @(negedge clk);

    // Owner drops exactly at the hold limit: plain release, no preempt.
    pulse_reset();
    bus_reqcyc = 5'b00011; exp_q.push_back(0);
    wait_new_grant();
    repeat (7) @(negedge clk);
    bus_reqcyc = 5'b00010; exp_q.push_back(1);
    @(negedge clk);
    check("tie_valid", {31'd0, bus_grant_valid}, 32'd0);
    check("tie_preempt", {31'd0, bus_preempt}, 32'd0);
    wait_new_grant();
    bus_reqcyc = '0; repeat (3) @(negedge clk);

    // Asynchronous reset mid-GRANT, then pointer restarts at 0.
    pulse_reset();
    bus_reqcyc = 5'b01000; exp_q.push_back(3);
    wait_new_grant();
    @(negedge clk);
    check("pre_rst_grant", {27'd0, bus_grant}, 32'h08);
    #2 reset = 1'b1;
    #1;
    check("async_rst_grant", {27'd0, bus_grant}, 32'd0);
    check("async_rst_valid", {31'd0, bus_grant_valid}, 32'd0);
    check("async_rst_id", {29'd0, bus_grant_id}, 32'd0);
    check("async_rst_preempt", {31'd0, bus_preempt}, 32'd0);
    bus_reqcyc = 5'b01001; exp_q.push_back(0);
    @(negedge clk);
    reset = 1'b0;
    wait_new_grant();
    check("post_rst_id", {29'd0, bus_grant_id}, 32'd0);
    bus_reqcyc = '0; repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
